// File: rtl/tx_pkg.sv
// Shared constants and state encoding for the serial transmit path
// (scheduler, transmitter and receiver).
package tx_pkg;

   localparam int DATA_W       = 7;   // payload width of the 7-bit transmitter
   localparam int FRAME_CYCLES = 11;  // start + 7 data + parity + stop + idle edge
   localparam int ID_W         = 3;   // width of a requester index (up to 8 requesters)

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } sched_state_t;

endpackage

// File: rtl/tx_scheduler_if.sv
// Bundle between the requesting clients and the transmit scheduler,
// including the scheduler's start/data outputs toward the transmitter.
interface tx_scheduler_if
   import tx_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PAY_W   = DATA_W
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*PAY_W-1:0] req_data;
   logic [NUM_REQ-1:0]       grant;
   logic [ID_W-1:0]          grant_id;
   logic                     busy;
   logic                     tx_start;
   logic [PAY_W-1:0]         tx_data;

   // Client side: presents requests and payloads, observes the schedule.
   modport master (
      output req, req_data,
      input  grant, grant_id, busy, tx_start, tx_data
   );

   // Scheduler side.
   modport slave (
      input  req, req_data,
      output grant, grant_id, busy, tx_start, tx_data
   );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request bit strictly after
// 'last', wrapping around, so 'last' itself has the lowest priority.
module rr_pick
   import tx_pkg::*;
#(
   parameter int NUM_REQ = 4
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last,
   output logic               any,
   output logic [ID_W-1:0]    winner
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   int   idx_s;
   logic hit_s;

   // Scan offsets from farthest to nearest so the nearest hit is the final assignment.
   always_comb begin
      any    = 1'b0;
      winner = {ID_W{1'b0}};
      idx_s  = 0;
      hit_s  = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx_s  = (int'(last) + k) % NUM_REQ;
         hit_s  = req[IDX_W'(idx_s)];
         any    = any | hit_s;
         winner = hit_s ? ID_W'(idx_s) : winner;
      end
   end
endmodule

// File: rtl/tx_scheduler.sv
// Round-robin scheduler sharing one serial transmitter between NUM_REQ
// clients. Grants one frame at a time and paces tx_start so successive
// pulses are at least FRAME_CYCLES clocks apart.
module tx_scheduler #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = tx_pkg::DATA_W,
   parameter int FRAME_CYCLES = tx_pkg::FRAME_CYCLES
)(
   input  logic           clk,
   input  logic           rstn,
   tx_scheduler_if.slave  bus
);
   import tx_pkg::*;

   localparam int CNT_W = $clog2(FRAME_CYCLES + 1);

   sched_state_t        state_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [ID_W-1:0]     last_r;
   logic [NUM_REQ-1:0]  grant_r;
   logic [ID_W-1:0]     grant_id_r;
   logic                busy_r;
   logic                tx_start_r;
   logic [DATA_W-1:0]   tx_data_r;

   logic                any_s;
   logic [ID_W-1:0]     winner_s;
   logic [DATA_W-1:0]   pick_data_s;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req    (bus.req),
      .last   (last_r),
      .any    (any_s),
      .winner (winner_s)
   );

   // Select the winning requester's payload slice.
   always_comb begin
      pick_data_s = {DATA_W{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         pick_data_s = (winner_s == ID_W'(i)) ? bus.req_data[i*DATA_W +: DATA_W] : pick_data_s;
      end
   end

   // FSM, pacing counter, round-robin pointer and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r    <= ST_IDLE;
         cnt_r      <= {CNT_W{1'b0}};
         last_r     <= ID_W'(NUM_REQ - 1);   // requester 0 wins the first arbitration
         grant_r    <= {NUM_REQ{1'b0}};
         grant_id_r <= {ID_W{1'b0}};
         busy_r     <= 1'b0;
         tx_start_r <= 1'b0;
         tx_data_r  <= {DATA_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_s) begin
                  tx_data_r  <= pick_data_s;
                  tx_start_r <= 1'b1;
                  grant_r    <= NUM_REQ'(1) << winner_s;
                  grant_id_r <= winner_s;
                  last_r     <= winner_s;
                  cnt_r      <= CNT_W'(FRAME_CYCLES - 1);
                  busy_r     <= 1'b1;
                  state_r    <= ST_WAIT;
               end else begin
                  tx_start_r <= 1'b0;
                  grant_r    <= {NUM_REQ{1'b0}};
                  busy_r     <= 1'b0;
               end
            end
            ST_WAIT: begin
               // Requests are ignored here; only the pacing counter runs.
               tx_start_r <= 1'b0;
               grant_r    <= {NUM_REQ{1'b0}};
               if (cnt_r == CNT_W'(1)) begin
                  cnt_r   <= {CNT_W{1'b0}};
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  cnt_r   <= cnt_r - CNT_W'(1);
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               cnt_r      <= {CNT_W{1'b0}};
               grant_r    <= {NUM_REQ{1'b0}};
               busy_r     <= 1'b0;
               tx_start_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant    = grant_r;
   assign bus.grant_id = grant_id_r;
   assign bus.busy     = busy_r;
   assign bus.tx_start = tx_start_r;
   assign bus.tx_data  = tx_data_r;
endmodule
